// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and byte-lane mask constants for the memory bus path.
package mem_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_WORD = 2'b11;

    function automatic logic [1:0] lane_mask(input logic byte_acc, input logic a0);
        return byte_acc ? (a0 ? MASK_HI : MASK_LO) : MASK_WORD;
    endfunction
endpackage

// File: rtl/mem_sequencer.sv
// mem_sequencer: turns single CPU byte/word requests into timed memory_bus transactions,
// one response per accepted request, odd-address word accesses answered with an error.
module mem_sequencer
    import mem_pkg::*;
#(
    parameter int READ_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [15:0] req_address,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_error,
    output logic [15:0] address,
    output logic [15:0] data_in,
    output logic [1:0]  write_mask,
    output logic        bus_enable,
    output logic        write_enable,
    input  logic [15:0] data_out
);
    logic [1:0]  state_q, state_d, mask_q, mask_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d, din_q, din_d, rsp_data_q, rsp_data_d, rd_word;
    logic        byte_q, byte_d, a0_q, a0_d, err_q, err_d, accept;

    assign req_ready = reset && state_q == ST_IDLE;
    assign accept    = req_valid && req_ready;
    assign rd_word   = byte_q ? {8'h00, a0_q ? data_out[15:8] : data_out[7:0]} : data_out;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        mask_d     = mask_q;
        byte_d     = byte_q;
        a0_d       = a0_q;
        rsp_data_d = rsp_data_q;
        err_d      = err_q;
        if (accept) begin
            addr_d = {req_address[15:1], 1'b0};
            din_d  = req_byte ? {2{req_data[7:0]}} : req_data;
            mask_d = lane_mask(req_byte, req_address[0]);
            byte_d = req_byte;
            a0_d   = req_address[0];
            cnt_d  = 3'(READ_WAIT);
            if (!req_byte && req_address[0]) begin
                state_d    = ST_RESP;
                rsp_data_d = '0;
                err_d      = 1'b1;
            end else begin
                state_d = req_write ? ST_WRITE : ST_READ;
            end
        end else if (state_q == ST_WRITE) begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
            err_d      = 1'b0;
        end else if (state_q == ST_READ) begin
            cnt_d = cnt_q - 3'd1;
            // the counter reaching 1 marks the last cycle of the block-RAM wait
            if (cnt_q == 3'd1) begin
                state_d    = ST_RESP;
                rsp_data_d = rd_word;
                err_d      = 1'b0;
            end
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            mask_q     <= MASK_NONE;
            byte_q     <= 1'b0;
            a0_q       <= 1'b0;
            rsp_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            mask_q     <= mask_d;
            byte_q     <= byte_d;
            a0_q       <= a0_d;
            rsp_data_q <= rsp_data_d;
            err_q      <= err_d;
        end
    end

    assign address      = addr_q;
    assign data_in      = din_q;
    assign write_mask   = state_q == ST_WRITE ? mask_q : MASK_NONE;
    assign bus_enable   = state_q == ST_READ || state_q == ST_WRITE;
    assign write_enable = state_q == ST_WRITE;
    assign rsp_valid    = state_q == ST_RESP;
    assign rsp_data     = rsp_data_q;
    assign rsp_error    = err_q;
endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: directed vector table plus hand-written sequences for back-to-back,
// reset-mid-read and READ_WAIT=1/7 latency behaviour.
module tb_mem_sequencer;
    logic        clk = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, req_byte = 1'b0;
    logic [15:0] req_address = '0, req_data = '0, data_out = '0;
    logic        req_ready, rsp_valid, rsp_error, bus_enable, write_enable;
    logic [15:0] rsp_data, address, data_in;
    logic [1:0]  write_mask;
    logic        r1, v1, e1, be1, we1, r7, v7, e7, be7, we7;
    logic [15:0] d1, a1, di1, d7, a7, di7;
    logic [1:0]  m1, m7;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    mem_sequencer #(.READ_WAIT(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_byte(req_byte), .req_address(req_address), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error), .address(address),
        .data_in(data_in), .write_mask(write_mask), .bus_enable(bus_enable),
        .write_enable(write_enable), .data_out(data_out));

    mem_sequencer #(.READ_WAIT(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r1),
        .req_write(req_write), .req_byte(req_byte), .req_address(req_address), .req_data(req_data),
        .rsp_valid(v1), .rsp_data(d1), .rsp_error(e1), .address(a1),
        .data_in(di1), .write_mask(m1), .bus_enable(be1),
        .write_enable(we1), .data_out(data_out));

    mem_sequencer #(.READ_WAIT(7)) dut7 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(r7),
        .req_write(req_write), .req_byte(req_byte), .req_address(req_address), .req_data(req_data),
        .rsp_valid(v7), .rsp_data(d7), .rsp_error(e7), .address(a7),
        .data_in(di7), .write_mask(m7), .bus_enable(be7),
        .write_enable(we7), .data_out(data_out));

    typedef struct {
        logic        wr, by;
        logic [15:0] addr, wdata, bus, exp_rsp, exp_addr, exp_din;
        logic [1:0]  exp_mask;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // one request on the READ_WAIT=2 instance, starting just after a rising edge
    task automatic run(input vec_t v);
        int lat = 0, we_n = 0, be_n = 0, bad = 0, wait_n = 0;
        req_valid = 1'b1; req_write = v.wr; req_byte = v.by;
        req_address = v.addr; req_data = v.wdata; data_out = v.bus;
        @(negedge clk);
        while (!req_ready && wait_n < 20) begin
            wait_n++;
            @(negedge clk);
        end
        chk("accept_ready", req_ready, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = k;
                chk("rsp_data", rsp_data, v.exp_rsp);
                chk("rsp_error", rsp_error, v.exp_err);
            end else begin
                we_n += int'(write_enable);
                be_n += int'(bus_enable);
                bad  += int'(req_ready);
                if (write_enable) begin
                    chk("wr_address", address, v.exp_addr);
                    chk("wr_data_in", data_in, v.exp_din);
                    chk("wr_mask", write_mask, v.exp_mask);
                end else if (bus_enable && write_mask != 2'b00) bad++;
            end
        end
        chk("latency", lat, v.lat);
        chk("we_cycles", we_n, (v.wr && !v.exp_err) ? 1 : 0);
        chk("be_cycles", be_n, v.exp_err ? 0 : (v.wr ? 1 : 2));
        chk("busy_glitch", bad, 0);
        chk("address_hold", address, v.exp_addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc, n_rsp, last, we_tot, l1, l2, l7, n1, n2, n7;
        logic take;
        logic [15:0] c1, c2, c7;
        //        wr    by    addr      wdata     bus       rsp       addr      din       mask   err  lat
        vecs[0] = '{1'b1, 1'b0, 16'h8002, 16'hBEEF, 16'h0000, 16'h0000, 16'h8002, 16'hBEEF, 2'b11, 1'b0, 2};
        vecs[1] = '{1'b0, 1'b0, 16'h8002, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h8002, 16'h0000, 2'b00, 1'b0, 3};
        vecs[2] = '{1'b1, 1'b1, 16'h8003, 16'h0055, 16'h0000, 16'h0000, 16'h8002, 16'h5555, 2'b10, 1'b0, 2};
        vecs[3] = '{1'b0, 1'b1, 16'h8003, 16'h0000, 16'h55EF, 16'h0055, 16'h8002, 16'h0000, 2'b00, 1'b0, 3};
        vecs[4] = '{1'b0, 1'b1, 16'h8002, 16'h0000, 16'h55EF, 16'h00EF, 16'h8002, 16'h0000, 2'b00, 1'b0, 3};
        vecs[5] = '{1'b1, 1'b1, 16'h8002, 16'h12A7, 16'h0000, 16'h0000, 16'h8002, 16'hA7A7, 2'b01, 1'b0, 2};
        vecs[6] = '{1'b0, 1'b0, 16'h0101, 16'h0000, 16'h1234, 16'h0000, 16'h0100, 16'h0000, 2'b00, 1'b1, 1};
        vecs[7] = '{1'b1, 1'b0, 16'h0003, 16'h7777, 16'h0000, 16'h0000, 16'h0002, 16'h7777, 2'b11, 1'b1, 1};
        vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h3400, 16'h0034, 16'hFFFE, 16'h0000, 2'b00, 1'b0, 3};
        vecs[9] = '{1'b1, 1'b1, 16'hFFFF, 16'h00C3, 16'h0000, 16'h0000, 16'hFFFE, 16'hC3C3, 2'b10, 1'b0, 2};

        repeat (2) @(negedge clk);
        chk("reset_ready", req_ready, 0);
        chk("reset_outs", {address, data_in, rsp_data, write_mask, bus_enable, write_enable, rsp_valid, rsp_error}, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("post_reset_ready", req_ready, 1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) run(vecs[i]);

        // back-to-back writes with req_valid held high
        acc = 0; n_rsp = 0; last = -1; we_tot = 0;
        req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0; req_address = 16'h0200; req_data = 16'h1234;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            we_tot += int'(write_enable);
            if (rsp_valid) begin
                n_rsp++;
                if (last >= 0) chk("b2b_gap", c - last, 3);
                last = c;
            end
            take = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (take) begin
                acc++;
                if (acc == 3) req_valid = 1'b0;
            end
        end
        chk("b2b_accepts", acc, 3);
        chk("b2b_rsp", n_rsp, 3);
        chk("b2b_we", we_tot, 3);

        // reset asserted during the first READ cycle
        run(vecs[1]);
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_address = 16'h4444;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("rd1_bus_enable", bus_enable, 1);
        #2 reset = 1'b0;
        #1;
        chk("mid_reset_ready", req_ready, 0);
        chk("mid_reset_outs", {address, data_in, rsp_data, write_mask, bus_enable, write_enable, rsp_valid, rsp_error}, 0);
        n_rsp = 0;
        repeat (3) begin
            @(negedge clk);
            n_rsp += int'(rsp_valid);
        end
        chk("mid_reset_no_rsp", n_rsp, 0);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("release_ready", {r1, req_ready, r7}, 3'b111);

        // same read accepted by READ_WAIT=1/2/7 instances; data_out changes every cycle
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_address = 16'h0040; data_out = 16'hA000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        data_out = 16'hA001;
        l1 = 0; l2 = 0; l7 = 0; n1 = 0; n2 = 0; n7 = 0; c1 = '0; c2 = '0; c7 = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (v1) begin l1 = k; n1++; c1 = d1; end
            if (rsp_valid) begin l2 = k; n2++; c2 = rsp_data; end
            if (v7) begin l7 = k; n7++; c7 = d7; end
            @(posedge clk);
            #1 data_out = 16'hA000 + 16'(k + 1);
        end
        chk("rw1_latency", l1, 2);
        chk("rw2_latency", l2, 3);
        chk("rw7_latency", l7, 8);
        chk("rw_pulses", {n1[3:0], n2[3:0], n7[3:0]}, 12'h111);
        chk("rw1_data", c1, 16'hA001);
        chk("rw2_data", c2, 16'hA002);
        chk("rw7_data", c7, 16'hA007);

        run(vecs[3]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_sequencer.md
# mem_sequencer

Bus-access stage sitting directly upstream of `memory_bus`: converts single CPU byte/word read and write requests into correctly timed `memory_bus` transactions. Handles byte-lane selection, the block-RAM read wait, and odd-address word-access errors (PDP-11 boundary error), returning one response per request. It is the only master of `memory_bus`.

## Interface
Parameters:
- `READ_WAIT`, 2, cycles `bus_enable`/address are held before read data is captured (legal 1..7).

Ports (clock and reset first):
- `clk`  input  1  system clock; all state changes on rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  CPU request present.
- `req_ready`  output  1  high only in IDLE; request accepted on `req_valid && req_ready`.
- `req_write`  input  1  1 = write, 0 = read.
- `req_byte`  input  1  1 = byte access, 0 = word access.
- `req_address`  input  16  byte address.
- `req_data`  input  16  write data; byte writes use `[7:0]`.
- `rsp_valid`  output  1  one-cycle pulse, one per accepted request.
- `rsp_data`  output  16  read data; byte reads zero-extended into `[7:0]`; 0 for writes/errors.
- `rsp_error`  output  1  valid with `rsp_valid`; word access at odd address.
- `address`  output  16  to `memory_bus.address`, word-aligned (`[0]` always 0).
- `data_in`  output  16  to `memory_bus.data_in`.
- `write_mask`  output  2  bit i = 1 enables byte lane i (`[0]` = bits 7:0).
- `bus_enable`  output  1  to `memory_bus.bus_enable`.
- `write_enable`  output  1  to `memory_bus.write_enable`.
- `data_out`  input  16  from `memory_bus.data_out`.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On accept, latch write/byte/address/data.
  - Word access with `req_address[0]`=1: no bus activity, go to RESP with `rsp_error`=1.
  - Write: go to WRITE.
  - Read: load wait counter with `READ_WAIT`, go to READ.
- WRITE (1 cycle): `bus_enable`=1, `write_enable`=1; then RESP.
  - Word: `data_in`=req_data, `write_mask`=2'b11.
  - Byte: `data_in`={req_data[7:0], req_data[7:0]}; `write_mask`=2'b10 if address[0] else 2'b01.
- READ: `bus_enable`=1, `write_enable`=0, `write_mask`=2'b00; counter decrements each cycle. In the cycle the counter reaches 1, capture `data_out` into the response register, then go to RESP.
  - Byte result: address[0] ? {8'h00, data_out[15:8]} : {8'h00, data_out[7:0]}.
- RESP (1 cycle): `rsp_valid`=1, `bus_enable`=0, `write_enable`=0; then IDLE.
- `address`={addr[15:1],1'b0} driven from accept until the next accept. No change outside an accept.
- `req_valid` outside IDLE is ignored. The CPU holds the request until `req_ready`.
- `rsp_data`/`rsp_error` hold their values until the next RESP.

## Timing
- Accept at edge N:
  - Write: WRITE during cycle N+1, `rsp_valid` in cycle N+2.
  - Read: READ during cycles N+1..N+READ_WAIT, `rsp_valid` in cycle N+READ_WAIT+1.
  - Error: `rsp_valid` in cycle N+1.
- Next accept no earlier than the edge ending the RESP cycle. Throughput: 1 write per 3 cycles, 1 read per READ_WAIT+2 cycles.
- `write_enable` is high for exactly one cycle per write, never during READ or RESP.
- Reset asserted (any state, including mid-WRITE/READ): immediately
  - state = IDLE;
  - `address`, `data_in`, `rsp_data` = 0;
  - `write_mask` = 2'b00;
  - `bus_enable`, `write_enable`, `rsp_valid`, `rsp_error` = 0;
  - `req_ready` = 0 while reset is low, 1 on the first cycle after release.
  
  An interrupted request produces no response.
- Address wrap: 16'hFFFF byte access goes to word 16'hFFFE, lane 1. No carry out of `address`.

## Structure
- Shared package `mem_pkg`: state encoding (2-bit IDLE/READ/WRITE/RESP) and lane-mask constants (MASK_NONE 2'b00, MASK_LO 2'b01, MASK_HI 2'b10, MASK_WORD 2'b11). `memory_bus` also uses the mask constants.
- No sub-module. Single module with a 3-bit wait counter and a response register.

## Test plan
- Word write 16'h8002 ← 16'hBEEF, then word read 16'h8002 (bus model returns after READ_WAIT=2) → `write_enable` pulse 1 cycle with mask 2'b11; read `rsp_data`=16'hBEEF at accept+3, `rsp_error`=0.
- Byte write 16'h8003 ← 16'h0055 → `address`=16'h8002, `data_in`=16'h5555, `write_mask`=2'b10; byte read 16'h8003 with bus word 16'h55EF → `rsp_data`=16'h0055.
- Word read 16'h0101 → `rsp_valid`+`rsp_error` at accept+1, `bus_enable` never asserted, `rsp_data`=0.
- `req_valid` held high back-to-back with 3 writes → exactly 3 accepts, 3 `rsp_valid` pulses, spacing 3 cycles.
- Reset pulled low during READ cycle 1 → all outputs at reset values combinationally; no `rsp_valid`; after release, `req_ready`=1 and the next read completes normally.
- READ_WAIT=1 and READ_WAIT=7 builds: `rsp_valid` at accept+2 and accept+8 respectively; captured data matches the `data_out` value present in the final READ cycle.
